muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the multicycle CPU datapath, replacing the separate fixed-width multiplier and divider with one shared, width-generic engine. It takes two operands from the A/B registers on a one-cycle start pulse, runs a shift-add multiply or restoring divide over WIDTH cycles, and returns a double-width result as HI/LO words with a one-cycle done pulse. The control FSM consumes done and loads the HI/LO registers. Signed operation and divide-by-zero flagging are built in.

---
 rtl/muldiv_if.sv | 19 +
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Handshake and operand/result bundle for muldiv_unit.
// The CPU controller drives the master side; the unit sits on the slave side.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (output start, op, is_signed, a, b,
                  input  hi, lo, busy, done, div_by_zero);
  modport slave  (input  start, op, is_signed, a, b,
                  output hi, lo, busy, done, div_by_zero);
endinterface

// File: rtl/muldiv_unit.sv
// Shared iterative shift-add multiplier / restoring divider, WIDTH cycles per op.
// Define MULDIV_SIGNED_EN to honour is_signed; otherwise every op is unsigned.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clock,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, stateNext;

  logic [CW-1:0]    cnt;
  logic             opReg;
  logic [WIDTH-1:0] accHi, accLo, bOp;
  logic             aNeg, bNeg;
  logic [WIDTH-1:0] aMag, bMag;
  logic [WIDTH:0]   mulSum, divShift, divDiff;
  logic             divGe;
  logic [WIDTH-1:0] stepHi, stepLo, fixHi, fixLo;
  logic             accept, isDbz;
`ifdef MULDIV_SIGNED_EN
  logic             negRes, negRem;
  logic [2*WIDTH-1:0] prod;
`endif

  assign accept = (state == IDLE) && bus.start;
  assign isDbz  = bus.op && (bus.b == '0);

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    aNeg = bus.is_signed & bus.a[WIDTH-1];
    bNeg = bus.is_signed & bus.b[WIDTH-1];
`else
    aNeg = 1'b0;
    bNeg = 1'b0;
`endif
    aMag = aNeg ? -bus.a : bus.a;
    bMag = bNeg ? -bus.b : bus.b;
  end

  // One iteration: mul adds bOp into the upper half when the multiplier LSB
  // is set and shifts right; div shifts left and subtracts when it fits.
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, bOp} : '0);
    divShift = {accHi, accLo[WIDTH-1]};
    divGe    = divShift >= {1'b0, bOp};
    divDiff  = divShift - {1'b0, bOp};
    if (opReg) begin
      stepHi = divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
      stepLo = {accLo[WIDTH-2:0], divGe};
    end else begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], accLo[WIDTH-1:1]};
    end
  end

  always_comb begin
    fixHi = accHi;
    fixLo = accLo;
`ifdef MULDIV_SIGNED_EN
    prod = {accHi, accLo};
    if (!opReg) begin
      if (negRes) prod = -prod;
      fixHi = prod[2*WIDTH-1:WIDTH];
      fixLo = prod[WIDTH-1:0];
    end else begin
      if (negRes) fixLo = -accLo;
      if (negRem) fixHi = -accHi;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (bus.start) stateNext = isDbz ? DONE : RUN;
      RUN:  if (cnt == CW'(1)) stateNext = FIX;
      FIX:  stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.hi          <= '0;
      bus.lo          <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      cnt             <= '0;
      opReg           <= 1'b0;
      accHi           <= '0;
      accLo           <= '0;
      bOp             <= '0;
`ifdef MULDIV_SIGNED_EN
      negRes          <= 1'b0;
      negRem          <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          opReg           <= bus.op;
          bus.div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
          negRes          <= aNeg ^ bNeg;
          negRem          <= aNeg;
`endif
          if (isDbz) begin
            // Divide by zero skips the engine: dividend passes through untouched.
            bus.hi          <= bus.a;
            bus.lo          <= '1;
            bus.div_by_zero <= 1'b1;
            bus.done        <= 1'b1;
          end else begin
            bus.busy <= 1'b1;
            cnt      <= CW'(WIDTH);
            accHi    <= '0;
            accLo    <= bus.op ? aMag : bMag;
            bOp      <= bus.op ? bMag : aMag;
          end
        end
        RUN: begin
          cnt   <= cnt - CW'(1);
          accHi <= stepHi;
          accLo <= stepLo;
        end
        FIX: begin
          bus.hi   <= fixHi;
          bus.lo   <= fixLo;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: WIDTH=32 and WIDTH=8 instances on one clock.
module tb_muldiv_unit;
  logic clock;
  logic reset;
  int   nChecks = 0;
  int   nFail   = 0;

  muldiv_if #(.WIDTH(32)) bus32();
  muldiv_if #(.WIDTH(8))  bus8();

  muldiv_unit #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
  muldiv_unit #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and % takes the dividend's sign, matching the required semantics.
  function automatic void model32(input bit op, input bit sgn, input logic [31:0] a, b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint sa, sb, p, q, r;
    bit s;
    s = sgn;
`ifndef MULDIV_SIGNED_EN
    s = 1'b0;
`endif
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    dbz = 1'b0;
    if (!op) begin
      p = sa * sb; hi = p[63:32]; lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
    end else begin
      q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0];
    end
  endfunction

  task automatic run32(input bit op, input bit sgn, input logic [31:0] a, b,
                       output int lat, output logic [31:0] hi, output logic [31:0] lo,
                       output logic dbz, output bit busyOk, output bit holdOk);
    logic [31:0] hi0, lo0;
    @(negedge clock);
    hi0 = bus32.hi; lo0 = bus32.lo;
    bus32.start = 1'b1; bus32.op = op; bus32.is_signed = sgn; bus32.a = a; bus32.b = b;
    @(posedge clock);
    lat = -1; busyOk = 1'b1; holdOk = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (k == 0) begin
        bus32.start = 1'b0; bus32.a = $urandom; bus32.b = $urandom;
        bus32.op = 1'($urandom); bus32.is_signed = 1'($urandom);
      end
      if (bus32.done === 1'b1) begin lat = k + 1; break; end
      if (bus32.busy !== 1'b1) busyOk = 1'b0;
      if (bus32.hi !== hi0 || bus32.lo !== lo0) holdOk = 1'b0;
    end
    hi = bus32.hi; lo = bus32.lo; dbz = bus32.div_by_zero;
  endtask

  task automatic run8(input bit op, input logic [7:0] a, b, input int extraAt,
                      output int lat, output logic [7:0] hi, output logic [7:0] lo);
    @(negedge clock);
    bus8.start = 1'b1; bus8.op = op; bus8.is_signed = 1'b0; bus8.a = a; bus8.b = b;
    @(posedge clock);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      bus8.start = (k == extraAt);
      if (k == extraAt) begin bus8.a = 8'd3; bus8.b = 8'd1; bus8.op = ~op; end
      if (bus8.done === 1'b1) begin lat = k + 1; break; end
    end
    bus8.start = 1'b0;
    hi = bus8.hi; lo = bus8.lo;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    nChecks++;
    if ({bus32.hi, bus32.lo, bus32.busy, bus32.done, bus32.div_by_zero} !== 67'd0) begin
      nFail++; $display("FAIL reset32: got hi=%h lo=%h busy=%b done=%b dbz=%b required all 0",
        bus32.hi, bus32.lo, bus32.busy, bus32.done, bus32.div_by_zero);
    end
    nChecks++;
    if ({bus8.hi, bus8.lo, bus8.busy, bus8.done, bus8.div_by_zero} !== 19'd0) begin
      nFail++; $display("FAIL reset8: got hi=%h lo=%h busy=%b done=%b dbz=%b required all 0",
        bus8.hi, bus8.lo, bus8.busy, bus8.done, bus8.div_by_zero);
    end
    reset = 1'b1;
  endtask

  task automatic test_mul_basic;
    int lat; logic [31:0] hi, lo; logic dbz; bit bOk, hOk;
    run32(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, lat, hi, lo, dbz, bOk, hOk);
    nChecks++;
    if (hi !== 32'h1) begin nFail++; $display("FAIL mul_hi: got %h required 00000001", hi); end
    nChecks++;
    if (lo !== 32'hFFFF_FFFE) begin nFail++; $display("FAIL mul_lo: got %h required fffffffe", lo); end
    nChecks++;
    if (lat !== 34) begin nFail++; $display("FAIL mul_latency: got %0d required 34", lat); end
    nChecks++;
    if (bOk !== 1'b1) begin nFail++; $display("FAIL mul_busy: got busy drop=%b required 1", bOk); end
  endtask

  task automatic test_signed;
    int lat; logic [31:0] hi, lo; logic dbz; bit bOk, hOk;
    logic [31:0] eHi, eLo;
`ifdef MULDIV_SIGNED_EN
    eHi = 32'hFFFF_FFFF; eLo = 32'hFFFF_FFF1;
`else
    eHi = 32'h0000_0004; eLo = 32'hFFFF_FFF1;
`endif
    run32(1'b0, 1'b1, -32'sd3, 32'd5, lat, hi, lo, dbz, bOk, hOk);
    nChecks++;
    if ({hi, lo} !== {eHi, eLo}) begin
      nFail++; $display("FAIL smul: got %h_%h required %h_%h", hi, lo, eHi, eLo);
    end
`ifdef MULDIV_SIGNED_EN
    eHi = 32'hFFFF_FFFF; eLo = 32'hFFFF_FFFD;
`else
    eHi = 32'h0000_0001; eLo = 32'h7FFF_FFFC;
`endif
    run32(1'b1, 1'b1, -32'sd7, 32'd2, lat, hi, lo, dbz, bOk, hOk);
    nChecks++;
    if ({hi, lo} !== {eHi, eLo}) begin
      nFail++; $display("FAIL sdiv: got rem=%h quo=%h required rem=%h quo=%h", hi, lo, eHi, eLo);
    end
`ifdef MULDIV_SIGNED_EN
    eHi = 32'h0; eLo = 32'h8000_0000;
`else
    eHi = 32'h8000_0000; eLo = 32'h0;
`endif
    run32(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, hi, lo, dbz, bOk, hOk);
    nChecks++;
    if ({hi, lo, dbz} !== {eHi, eLo, 1'b0}) begin
      nFail++; $display("FAIL sdiv_minneg: got rem=%h quo=%h dbz=%b required rem=%h quo=%h dbz=0",
        hi, lo, dbz, eHi, eLo);
    end
  endtask

  task automatic test_div_zero;
    int lat; logic [31:0] hi, lo; logic dbz; bit bOk, hOk;
    run32(1'b1, 1'b0, 32'h1234, 32'd0, lat, hi, lo, dbz, bOk, hOk);
    nChecks++;
    if (lat !== 1) begin nFail++; $display("FAIL dbz_latency: got %0d required 1", lat); end
    nChecks++;
    if ({hi, lo, dbz} !== {32'h1234, 32'hFFFF_FFFF, 1'b1}) begin
      nFail++; $display("FAIL dbz_result: got hi=%h lo=%h dbz=%b required 00001234 ffffffff 1", hi, lo, dbz);
    end
    repeat (4) @(negedge clock);
    nChecks++;
    if (bus32.div_by_zero !== 1'b1) begin
      nFail++; $display("FAIL dbz_hold: got %b required 1", bus32.div_by_zero);
    end
    run32(1'b1, 1'b0, 32'd100, 32'd9, lat, hi, lo, dbz, bOk, hOk);
    nChecks++;
    if ({hi, lo, dbz} !== {32'd1, 32'd11, 1'b0}) begin
      nFail++; $display("FAIL dbz_clear: got hi=%h lo=%h dbz=%b required 1 0b 0", hi, lo, dbz);
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] hi, lo, eHi, eLo, a, b; logic dbz, eDbz; bit bOk, hOk, op, sgn;
    for (int i = 0; i < 30; i++) begin
      op = 1'($urandom); sgn = 1'($urandom);
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(0, 50));
        default: ;
      endcase
      model32(op, sgn, a, b, eHi, eLo, eDbz);
      run32(op, sgn, a, b, lat, hi, lo, dbz, bOk, hOk);
      nChecks++;
      if ({hi, lo, dbz} !== {eHi, eLo, eDbz}) begin
        nFail++; $display("FAIL rand_result[%0d] op=%b s=%b a=%h b=%h: got %h_%h dbz=%b required %h_%h dbz=%b",
          i, op, sgn, a, b, hi, lo, dbz, eHi, eLo, eDbz);
      end
      nChecks++;
      if (lat !== (eDbz ? 1 : 34)) begin
        nFail++; $display("FAIL rand_latency[%0d]: got %0d required %0d", i, lat, eDbz ? 1 : 34);
      end
      nChecks++;
      if (hOk !== 1'b1) begin nFail++; $display("FAIL rand_hold[%0d]: hi/lo moved before done", i); end
      if (!eDbz) begin
        nChecks++;
        if (bOk !== 1'b1) begin nFail++; $display("FAIL rand_busy[%0d]: busy dropped before done", i); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] hi, lo; logic dbz; bit bOk, hOk, sawDone;
    @(negedge clock);
    bus32.start = 1'b1; bus32.op = 1'b0; bus32.is_signed = 1'b0; bus32.a = 32'd1000; bus32.b = 32'd3;
    @(posedge clock);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (k == 0) bus32.start = 1'b0;
      if (k == 9) reset = 1'b0;
      if (k == 10) begin
        nChecks++;
        if ({bus32.hi, bus32.lo, bus32.busy, bus32.done, bus32.div_by_zero} !== 67'd0) begin
          nFail++; $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b dbz=%b required all 0",
            bus32.hi, bus32.lo, bus32.busy, bus32.done, bus32.div_by_zero);
        end
        bus32.start = 1'b1;
      end
      if (k == 11) begin reset = 1'b1; bus32.start = 1'b0; end
    end
    sawDone = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (bus32.done !== 1'b0 || bus32.busy !== 1'b0) sawDone = 1'b1;
    end
    nChecks++;
    if (sawDone !== 1'b0) begin nFail++; $display("FAIL reset_abort: got activity=%b required 0", sawDone); end
    run32(1'b0, 1'b0, 32'd1000, 32'd3, lat, hi, lo, dbz, bOk, hOk);
    nChecks++;
    if ({hi, lo, lat} !== {32'd0, 32'd3000, 34}) begin
      nFail++; $display("FAIL reset_recover: got hi=%h lo=%h lat=%0d required 0 bb8 34", hi, lo, lat);
    end
  endtask

  task automatic test_width8;
    int lat; logic [7:0] hi, lo; bit act;
    run8(1'b1, 8'd200, 8'd7, 2, lat, hi, lo);
    nChecks++;
    if ({hi, lo} !== {8'd4, 8'd28}) begin
      nFail++; $display("FAIL w8_div: got rem=%0d quo=%0d required 4 28", hi, lo);
    end
    nChecks++;
    if (lat !== 10) begin nFail++; $display("FAIL w8_latency: got %0d required 10", lat); end
    // lat loop leaves us at the done negedge: a start here lands in DONE.
    bus8.start = 1'b1; bus8.op = 1'b0; bus8.a = 8'd10; bus8.b = 8'd3;
    @(negedge clock);
    bus8.start = 1'b0;
    act = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || {bus8.hi, bus8.lo} !== {8'd4, 8'd28}) act = 1'b1;
    end
    nChecks++;
    if (act !== 1'b0) begin nFail++; $display("FAIL w8_start_in_done: got activity=%b required 0", act); end
    run8(1'b0, 8'hFF, 8'hFF, -1, lat, hi, lo);
    nChecks++;
    if ({hi, lo, lat} !== {16'(255 * 255), 10}) begin
      nFail++; $display("FAIL w8_mul: got %h_%h lat=%0d required fe01 10", hi, lo, lat);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus32.start = 1'b0; bus32.op = 1'b0; bus32.is_signed = 1'b0; bus32.a = '0; bus32.b = '0;
    bus8.start = 1'b0;  bus8.op = 1'b0;  bus8.is_signed = 1'b0;  bus8.a = '0;  bus8.b = '0;
    test_reset;
    test_mul_basic;
    test_signed;
    test_div_zero;
    test_random;
    test_reset_mid;
    test_width8;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
